color_led_driver: RTL and testbench

// - Downstream of the colour-sensor detector: consumes its 2-bit colour code
//   (0 none, 1 red, 2 green, 3 blue) and drives the board RGB LED.
// - Qualifies the code for stability, latches it, and holds it for a minimum

---
 rtl/color_led_driver.sv | 213 +++++++++++++++++++++
 tb/tb_color_led_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/color_led_driver.sv
// rtl/color_led_driver.sv - colour-code qualifier, display hold FSM and PWM RGB LED driver
//
// Purpose:
//   Takes the 2-bit colour code from the colour-sensor detector, synchronises
//   it, requires it to be stable for STABLE_CYCLES samples, latches it as the
//   shown colour and holds it for at least HOLD_CYCLES before another change
//   is accepted. The matching RGB channel is driven with a PWM brightness.
//
// Optional feature macro: COLOR_LED_BLINK_EN
//   Defined   : LED additionally blinks while in SHOW (hold_cnt[BLINK_BIT]).
//   Undefined : SHOW and FREE drive identically (steady PWM).
//
// Ports:
//   clk_1MHz      in   1  system clock
//   rst_n         in   1  asynchronous active-low reset
//   color         in   2  colour code (0 none, 1 red, 2 green, 3 blue)
//   led_en        in   1  global LED enable, gates led_r/g/b only
//   led_r         out  1  red LED drive, registered
//   led_g         out  1  green LED drive, registered
//   led_b         out  1  blue LED drive, registered
//   shown_color   out  2  currently latched colour, 0 = none
//   color_update  out  1  one-cycle pulse when shown_color changes
//   hold_active   out  1  high while in SHOW

module color_led_driver #(
   parameter int STABLE_CYCLES = 1000,
   parameter int HOLD_CYCLES   = 500000,
   parameter int PWM_BITS      = 8,
   parameter int DUTY          = 64,
   parameter int BLINK_BIT     = 16
) (
   input  logic       clk_1MHz,
   input  logic       rst_n,
   input  logic [1:0] color,
   input  logic       led_en,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b,
   output logic [1:0] shown_color,
   output logic       color_update,
   output logic       hold_active
);

   localparam int SW       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int HW_BASE  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   // Hold counter is also wide enough to carry the blink bit.
   localparam int HW       = (HW_BASE > BLINK_BIT + 1) ? HW_BASE : BLINK_BIT + 1;

   localparam logic [SW-1:0]     STAB_MAX = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0]     HOLD_MAX = HW'(HOLD_CYCLES - 1);
   localparam logic [PWM_BITS:0] DUTY_W   = (PWM_BITS + 1)'(DUTY);
   localparam bit                DUTY_FULL = (DUTY == (1 << PWM_BITS));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      FREE = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // Input synchroniser (2 flops)
   // ---------------------------------------------------------------
   logic [1:0] color_s1_q;
   logic [1:0] color_s_q;

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         color_s1_q <= 2'd0;
         color_s_q  <= 2'd0;
      end else begin
         color_s1_q <= color;
         color_s_q  <= color_s1_q;
      end
   end

   // ---------------------------------------------------------------
   // Stability qualifier
   // ---------------------------------------------------------------
   logic [1:0]    cand_q,     cand_d;
   logic [SW-1:0] stab_cnt_q, stab_cnt_d;
   logic          qual;

   always_comb begin
      cand_d     = cand_q;
      stab_cnt_d = stab_cnt_q;
      if (color_s_q != cand_q) begin
         cand_d     = color_s_q;
         stab_cnt_d = '0;
      end else if (stab_cnt_q != STAB_MAX) begin
         stab_cnt_d = stab_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         cand_q     <= 2'd0;
         stab_cnt_q <= '0;
      end else begin
         cand_q     <= cand_d;
         stab_cnt_q <= stab_cnt_d;
      end
   end

   assign qual = (stab_cnt_q == STAB_MAX);

   // ---------------------------------------------------------------
   // Display FSM
   // ---------------------------------------------------------------
   state_t        state_q;
   logic [1:0]    shown_q;
   logic          update_q;
   logic          hold_active_q;
   logic [HW-1:0] hold_cnt_q;

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         shown_q       <= 2'd0;
         update_q      <= 1'b0;
         hold_active_q <= 1'b0;
         hold_cnt_q    <= '0;
      end else begin
         update_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (qual && cand_q != 2'd0) begin
                  state_q       <= SHOW;
                  shown_q       <= cand_q;
                  update_q      <= 1'b1;
                  hold_active_q <= 1'b1;
                  hold_cnt_q    <= '0;
               end
            end
            SHOW: begin
               // Qualified codes are ignored here; on expiry we only move to
               // FREE, and a still-qualified code is taken the cycle after.
               if (hold_cnt_q == HOLD_MAX) begin
                  state_q       <= FREE;
                  hold_active_q <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            FREE: begin
               if (qual && cand_q != shown_q) begin
                  shown_q  <= cand_q;
                  update_q <= 1'b1;
                  if (cand_q == 2'd0) begin
                     state_q <= IDLE;
                  end else begin
                     state_q       <= SHOW;
                     hold_active_q <= 1'b1;
                     hold_cnt_q    <= '0;
                  end
               end
            end
            default: begin
               state_q       <= IDLE;
               shown_q       <= 2'd0;
               hold_active_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // PWM and LED drive
   // ---------------------------------------------------------------
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic                pwm_on;
   logic                blink_ok;
   logic                drive;
   logic                led_r_q, led_g_q, led_b_q;

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
   end

   // Extra top bit lets DUTY reach 2**PWM_BITS without truncating to 0.
   assign pwm_on = DUTY_FULL || ({1'b0, pwm_cnt_q} < DUTY_W);

`ifdef COLOR_LED_BLINK_EN
   assign blink_ok = (state_q != SHOW) || !hold_cnt_q[BLINK_BIT];
`else
   assign blink_ok = 1'b1;
`endif

   assign drive = led_en && (state_q != IDLE) && pwm_on && blink_ok;

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         led_r_q <= 1'b0;
         led_g_q <= 1'b0;
         led_b_q <= 1'b0;
      end else begin
         led_r_q <= drive && (shown_q == 2'd1);
         led_g_q <= drive && (shown_q == 2'd2);
         led_b_q <= drive && (shown_q == 2'd3);
      end
   end

   assign led_r        = led_r_q;
   assign led_g        = led_g_q;
   assign led_b        = led_b_q;
   assign shown_color  = shown_q;
   assign color_update = update_q;
   assign hold_active  = hold_active_q;

endmodule

// File: tb/tb_color_led_driver.sv
// tb/tb_color_led_driver.sv - directed self-checking bench for color_led_driver

module tb_color_led_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] color;
   logic       led_en;

   logic       led_r, led_g, led_b, color_update, hold_active;
   logic [1:0] shown_color;
   logic       f_led_r, f_led_g, f_led_b, f_color_update, f_hold_active;
   logic [1:0] f_shown_color;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   color_led_driver #(
      .STABLE_CYCLES(4), .HOLD_CYCLES(20), .PWM_BITS(3), .DUTY(4), .BLINK_BIT(16)
   ) dut (
      .clk_1MHz(clk), .rst_n(rst_n), .color(color), .led_en(led_en),
      .led_r(led_r), .led_g(led_g), .led_b(led_b),
      .shown_color(shown_color), .color_update(color_update), .hold_active(hold_active)
   );

   color_led_driver #(
      .STABLE_CYCLES(4), .HOLD_CYCLES(20), .PWM_BITS(3), .DUTY(8), .BLINK_BIT(16)
   ) dut_full (
      .clk_1MHz(clk), .rst_n(rst_n), .color(color), .led_en(led_en),
      .led_r(f_led_r), .led_g(f_led_g), .led_b(f_led_b),
      .shown_color(f_shown_color), .color_update(f_color_update), .hold_active(f_hold_active)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // New code applied just before the call: 2 sync + 4 qualify + 1 FSM edge.
   task automatic expect_pulse(input string tag, input logic [1:0] exp_color);
      int early = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (color_update) early++;
      end
      check({tag, "_early"}, early, 0);
      tick();
      check({tag, "_pulse"}, color_update, 1);
      check({tag, "_shown"}, shown_color, exp_color);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt_g, cnt_g8, cnt_rb, cnt_full, cnt_any, cnt_upd, bad;

      // ---- Reset state ----
      rst_n  = 1'b0;
      color  = 2'd2;
      led_en = 1'b1;
      repeat (3) tick();
      check("rst_shown", shown_color, 0);
      check("rst_update", color_update, 0);
      check("rst_leds", {led_r, led_g, led_b}, 0);
      check("rst_hold", hold_active, 0);

      // ---- Test 1: qualify green after reset ----
      rst_n = 1'b1;
      expect_pulse("t1", 2'd2);
      check("t1_hold", hold_active, 1);
      tick();
      check("t1_single_pulse", color_update, 0);
      cnt_g = 0; cnt_g8 = 0; cnt_rb = 0; cnt_full = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (led_g) begin cnt_g++; if (i < 8) cnt_g8++; end
         if (led_r || led_b) cnt_rb++;
         if (f_led_g) cnt_full++;
      end
      check("t1_g_first8", cnt_g8, 4);
      check("t1_g_16", cnt_g, 8);
      check("t1_rb", cnt_rb, 0);
      check("t6_full_duty", cnt_full, 16);

      // ---- Test 6: led_en gating ----
      led_en = 1'b0;
      cnt_any = 0; cnt_upd = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (led_r || led_g || led_b || f_led_r || f_led_g || f_led_b) cnt_any++;
         if (color_update) cnt_upd++;
      end
      check("t6_leds_off", cnt_any, 0);
      check("t6_no_update", cnt_upd, 0);
      check("t6_shown", shown_color, 2);
      check("t6_free", hold_active, 0);
      led_en = 1'b1;
      cnt_full = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (f_led_g) cnt_full++;
      end
      check("t6_full_reenabled", cnt_full, 8);

      // ---- Return to IDLE from FREE ----
      color = 2'd0;
      expect_pulse("idle", 2'd0);
      check("idle_hold", hold_active, 0);

      // ---- Test 2: short glitch in IDLE ----
      color = 2'd1;
      repeat (3) tick();
      color = 2'd0;
      cnt_upd = 0; cnt_any = 0; bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (color_update) cnt_upd++;
         if (led_r || led_g || led_b) cnt_any++;
         if (shown_color != 2'd0) bad++;
      end
      check("t2_updates", cnt_upd, 0);
      check("t2_leds", cnt_any, 0);
      check("t2_shown", bad, 0);

      // ---- Test 3: change during SHOW is deferred ----
      color = 2'd1;
      expect_pulse("t3a", 2'd1);
      bad = 0;
      for (int k = 1; k <= 19; k++) begin
         tick();
         if (!hold_active || shown_color != 2'd1) bad++;
         if (k == 5) color = 2'd3;
      end
      check("t3_held", bad, 0);
      tick();
      check("t3_free_hold", hold_active, 0);
      check("t3_free_shown", shown_color, 1);
      check("t3_free_update", color_update, 0);
      tick();
      check("t3_new_pulse", color_update, 1);
      check("t3_new_shown", shown_color, 3);
      check("t3_new_hold", hold_active, 1);

      // ---- Test 4: blue in SHOW, then none in FREE ----
      cnt_g = 0; cnt_rb = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (led_b) cnt_g++;
         if (led_r || led_g) cnt_rb++;
      end
      check("t4_b_16", cnt_g, 8);
      check("t4_rg", cnt_rb, 0);
      repeat (4) tick();
      check("t4_free_hold", hold_active, 0);
      check("t4_free_shown", shown_color, 3);
      color = 2'd0;
      expect_pulse("t4", 2'd0);
      check("t4_idle_hold", hold_active, 0);
      cnt_any = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (led_r || led_g || led_b) cnt_any++;
      end
      check("t4_leds_off", cnt_any, 0);

      // ---- Test 5: async reset mid-SHOW ----
      color = 2'd2;
      expect_pulse("t5a", 2'd2);
      repeat (3) tick();
      check("t5_pre_hold", hold_active, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_outs", {led_r, led_g, led_b, shown_color, color_update, hold_active}, 0);
      check("t5_async_full", {f_led_r, f_led_g, f_led_b, f_shown_color}, 0);
      tick();
      rst_n = 1'b1;
      expect_pulse("t5b", 2'd2);
      check("t5b_hold", hold_active, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
